frame_buffer_scheduler: RTL
===========================

Name: frame_buffer_scheduler

Overview:
Sequences DDR traffic for the stereo frame buffer. Decides when the AXI4 burst master issues a write burst (drain the camera-1 write FIFO) or a read burst (refill the read FIFO that feeds the delayed video1 output). Generates burst addresses and manages a double-buffered (ping-pong) frame region so the read side never reads the frame currently being written. Sits between the FIFO level counters and the burst engine, in the memory clock domain.

Parameters:
ADDR_WIDTH, 49, width of cmd_addr
BASE_ADDR, 'h0, byte address of buffer 0
FRAME_BYTES, 33177600, bytes per frame region; multiple of BURST_BYTES
BURST_LEN, 16, beats per burst
BEAT_BYTES, 16, bytes per beat (128-bit bus)
FIFO_DEPTH, 4096, depth of each FIFO in beats
WR_URGENT, 3072, write FIFO level at which writes get absolute priority

Ports:
ACLK  in  1  memory clock
ARESET  in  1  asynchronous active-high reset
wr_fifo_count  in  12  beats held in write FIFO (read-side count)
rd_fifo_count  in  12  beats held in read FIFO (write-side count)
frame_start_wr  in  1  one-cycle pulse, first beat of new input frame
frame_start_rd  in  1  one-cycle pulse, first beat of new output frame
cmd_valid  out  1  burst command valid
cmd_ready  in  1  burst engine accepts command
cmd_write  out  1  1 = write burst, 0 = read burst
cmd_addr  out  ADDR_WIDTH  burst start byte address
cmd_len  out  8  AXI LEN, constant BURST_LEN-1
cmd_done  in  1  one-cycle pulse, burst fully completed (last B or RLAST)
wr_buf  out  1  buffer index being written
rd_buf  out  1  buffer index being read
overflow_err  out  1  sticky; write FIFO reached FIFO_DEPTH
status  out  4  {state[1:0], wr_frame_done, rd_frame_done}

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_valid=0, cmd_write=0, cmd_addr=BASE_ADDR, cmd_len=BURST_LEN-1 always; wr_buf=0, rd_buf=1; both offsets 0; wr_frame_done=1, rd_frame_done=1 (idle until first frame_start); pending flags 0; overflow_err=0.
- BURST_BYTES = BURST_LEN*BEAT_BYTES. wr_ok = !wr_frame_done && wr_fifo_count >= BURST_LEN. rd_ok = !rd_frame_done && (FIFO_DEPTH - rd_fifo_count) >= BURST_LEN; compute in 13 bits, no wrap.
- FSM IDLE -> ARB -> ISSUE -> WAIT -> IDLE.
- IDLE: apply pending frame starts, then go to ARB.
- ARB (1 cycle): pick the request, else return to IDLE.
  - wr_fifo_count >= WR_URGENT and wr_ok: write.
  - Otherwise round-robin between wr_ok and rd_ok. The last-granted flag toggles only on a grant. If only one is ok, grant it.
  - Register cmd_write and cmd_addr = BASE_ADDR + buf*FRAME_BYTES + offset, where buf/offset are wr_buf/wr_off or rd_buf/rd_off.
- ISSUE: cmd_valid=1; cmd_write and cmd_addr stay stable until cmd_valid && cmd_ready. On that handshake: cmd_valid drops the next cycle and the FSM goes to WAIT. Minimum latency from ARB decision to cmd_valid is 1 cycle.
- WAIT: on cmd_done, offset += BURST_BYTES for the granted side. If the new offset == FRAME_BYTES: offset=0 and that side's frame_done=1. Then go to IDLE. Only one outstanding command at a time.
- frame_start_wr is latched into pend_wr in any state; it is applied only in IDLE:
  - Toggle wr_buf, wr_off=0, wr_frame_done=0.
  - rd_buf is not changed by this.
- frame_start_rd is latched into pend_rd; it is applied in IDLE:
  - rd_buf = previous completed write buffer (~wr_buf as updated in this same IDLE cycle), rd_off=0, rd_frame_done=0.
- Both pending in the same IDLE cycle: apply the write update first, then the read update uses the new ~wr_buf.
- frame_start while that side's frame is mid-way: abandon it (offset reset). No error is flagged.
- overflow_err is set when wr_fifo_count == FIFO_DEPTH-1 or more; it is cleared only by ARESET.
- ARESET asserted mid-burst: immediate return to reset values. The burst engine is reset by the same signal.

Test Plan:
Use FRAME_BYTES=1024, BURST_LEN=16, BEAT_BYTES=16, BASE_ADDR='h1000, with a cmd_done responder 4 cycles after handshake.
- Reset then idle: no frame_start -> cmd_valid stays 0; wr_buf=0, rd_buf=1, status[1:0]=11.
- Write-only frame: frame_start_wr, wr_fifo_count=64 -> expected results:
  - Four write commands at 'h1400, 'h1500, 'h1600, 'h1700 (wr_buf=1).
  - Then wr_frame_done=1 and no further commands.
- Round-robin: both sides ok, wr_fifo_count=32 -> commands alternate W,R,W,R. Reads start at 'h1000 after frame_start_rd.
- Urgent priority: wr_fifo_count=3072, rd_ok=1 -> consecutive write grants.
- Handshake stall: hold cmd_ready=0 for 10 cycles -> cmd_valid, cmd_addr and cmd_write stay stable; exactly one command is accepted.
- Simultaneous frame_start_wr and frame_start_rd during WAIT -> both are applied in the next IDLE: wr_buf toggles, rd_buf = new ~wr_buf, offsets = 0. Async ARESET mid-ISSUE -> cmd_valid=0 in the same cycle.

Source files
------------

// File: rtl/frame_buffer_scheduler_if.sv
// Burst command channel between the frame buffer scheduler and the AXI4
// burst engine. One command is outstanding at a time; cmd_done closes it.
//
// Handshake: cmd_valid/cmd_ready follow strict valid/ready rules. Once
// cmd_valid is high, cmd_write and cmd_addr stay stable and cmd_valid
// stays high until the cycle in which cmd_valid && cmd_ready, which is
// the transfer. cmd_done is a one-cycle pulse that needs no ready.
interface frame_buffer_scheduler_if #(
  parameter int ADDR_WIDTH = 49
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic                  cmd_done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: arbitrates write bursts (drain the camera write
// FIFO) against read bursts (refill the delayed-video read FIFO). It
// generates burst addresses inside two ping-pong frame regions, so the read
// side always reads the last completed frame and never the one being written.
module frame_buffer_scheduler #(
  parameter int                    ADDR_WIDTH  = 49,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    FRAME_BYTES = 33177600,
  parameter int                    BURST_LEN   = 16,
  parameter int                    BEAT_BYTES  = 16,
  parameter int                    FIFO_DEPTH  = 4096,
  parameter int                    WR_URGENT   = 3072
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [11:0]               wr_fifo_count,
  input  logic [11:0]               rd_fifo_count,
  input  logic                      frame_start_wr,
  input  logic                      frame_start_rd,
  frame_buffer_scheduler_if.master  cmd,
  output logic                      wr_buf,
  output logic                      rd_buf,
  output logic                      overflow_err,
  output logic [3:0]                status
);

  localparam int                    BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam logic [ADDR_WIDTH-1:0] BURST_A     = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] FRAME_A     = ADDR_WIDTH'(FRAME_BYTES);
  // FIFO level arithmetic runs in 13 bits so that depth - count cannot wrap.
  localparam logic [12:0]           DEPTH13     = 13'(FIFO_DEPTH);
  localparam logic [12:0]           BLEN13      = 13'(BURST_LEN);
  localparam logic [12:0]           URGENT13    = 13'(WR_URGENT);
  localparam logic [12:0]           OVF13       = 13'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                  wr_buf_q, wr_buf_d;
  logic                  rd_buf_q, rd_buf_d;
  logic [ADDR_WIDTH-1:0] wr_off_q, wr_off_d;
  logic [ADDR_WIDTH-1:0] rd_off_q, rd_off_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  pend_wr_q, pend_wr_d;
  logic                  pend_rd_q, pend_rd_d;
  logic                  last_wr_q, last_wr_d;
  logic                  overflow_q, overflow_d;

  logic                  wr_ok, rd_ok;
  logic                  gnt_wr, gnt_rd;
  logic                  sel_buf;
  logic [ADDR_WIDTH-1:0] sel_off;
  logic [ADDR_WIDTH-1:0] wr_nxt, rd_nxt;

  // Request qualification from FIFO levels and per-side frame progress.
  always_comb begin
    wr_ok = !wr_done_q && ({1'b0, wr_fifo_count} >= BLEN13);
    rd_ok = !rd_done_q && ((DEPTH13 - {1'b0, rd_fifo_count}) >= BLEN13);
  end

  // Next-state logic: frame-start bookkeeping, arbitration, offset advance.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    wr_buf_d    = wr_buf_q;
    rd_buf_d    = rd_buf_q;
    wr_off_d    = wr_off_q;
    rd_off_d    = rd_off_q;
    wr_done_d   = wr_done_q;
    rd_done_d   = rd_done_q;
    last_wr_d   = last_wr_q;
    pend_wr_d   = pend_wr_q | frame_start_wr;
    pend_rd_d   = pend_rd_q | frame_start_rd;
    overflow_d  = overflow_q | ({1'b0, wr_fifo_count} >= OVF13);
    gnt_wr      = 1'b0;
    gnt_rd      = 1'b0;
    sel_buf     = 1'b0;
    sel_off     = '0;
    wr_nxt      = wr_off_q + BURST_A;
    rd_nxt      = rd_off_q + BURST_A;

    unique case (state_q)
      S_IDLE: begin
        // The write update goes first, so the read side picks up the buffer
        // that has just completed (the complement of the new write buffer).
        if (pend_wr_q) begin
          wr_buf_d  = ~wr_buf_q;
          wr_off_d  = '0;
          wr_done_d = 1'b0;
          pend_wr_d = frame_start_wr;
        end
        if (pend_rd_q) begin
          rd_buf_d  = ~wr_buf_d;
          rd_off_d  = '0;
          rd_done_d = 1'b0;
          pend_rd_d = frame_start_rd;
        end
        state_d = S_ARB;
      end

      S_ARB: begin
        if (({1'b0, wr_fifo_count} >= URGENT13) && wr_ok) begin
          gnt_wr = 1'b1;
        end else if (wr_ok && rd_ok) begin
          gnt_wr = !last_wr_q;
          gnt_rd = last_wr_q;
        end else begin
          gnt_wr = wr_ok;
          gnt_rd = rd_ok;
        end
        sel_buf = gnt_wr ? wr_buf_q : rd_buf_q;
        sel_off = gnt_wr ? wr_off_q : rd_off_q;
        if (gnt_wr || gnt_rd) begin
          cmd_write_d = gnt_wr;
          cmd_addr_d  = BASE_ADDR + (sel_buf ? FRAME_A : '0) + sel_off;
          cmd_valid_d = 1'b1;
          last_wr_d   = gnt_wr;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (cmd_valid_q && cmd.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cmd.cmd_done) begin
          if (cmd_write_q) begin
            if (wr_nxt == FRAME_A) begin
              wr_off_d  = '0;
              wr_done_d = 1'b1;
            end else begin
              wr_off_d = wr_nxt;
            end
          end else begin
            if (rd_nxt == FRAME_A) begin
              rd_off_d  = '0;
              rd_done_d = 1'b1;
            end else begin
              rd_off_d = rd_nxt;
            end
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset leaves both sides idle until their first frame start.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= BASE_ADDR;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b1;
      wr_off_q    <= '0;
      rd_off_q    <= '0;
      wr_done_q   <= 1'b1;
      rd_done_q   <= 1'b1;
      pend_wr_q   <= 1'b0;
      pend_rd_q   <= 1'b0;
      last_wr_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      last_wr_q   <= last_wr_d;
      overflow_q  <= overflow_d;
    end
  end

  // Output mapping; status exposes the FSM state alongside the frame-done flags.
  always_comb begin
    cmd.cmd_valid = cmd_valid_q;
    cmd.cmd_write = cmd_write_q;
    cmd.cmd_addr  = cmd_addr_q;
    cmd.cmd_len   = 8'(BURST_LEN - 1);
    wr_buf        = wr_buf_q;
    rd_buf        = rd_buf_q;
    overflow_err  = overflow_q;
    status        = {state_q, wr_done_q, rd_done_q};
  end

endmodule
